imem_loader: RTL

Byte-stream program loader that writes the processor's instruction memory. It accepts a framed stream of bytes over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to consecutive imem addresses starting at 0. The processor core is held in reset until the image has loaded cleanly. The loader sits between the host-link receiver and the imem write port in the wrapper, as the writer counterpart to the core's imem read side.

---
 rtl/imem_loader_if.sv | 19 +
 rtl/imem_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake from the host-link receiver.
// Ports: valid/data (sender -> loader), ready (loader -> sender).
interface imem_loader_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed big-endian byte stream into imem words
// and holds the core in reset until the image has loaded cleanly.
// Ports: clock, reset (async, active-high), rx (slave byte handshake),
//   reload (restart from DONE/ERR), imem_wren/imem_addr/imem_wdata
//   (imem write port), cpu_reset, done, error (status).
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_loader_if.slave          rx,
    input  logic                  reload,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = S_CSUM;
`else
    localparam state_t TAIL = S_DONE;
`endif

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t                  state, state_n;
    logic [1:0]              byte_cnt;
    logic [31:0]             count;
    logic [23:0]             word;
    logic [ADDR_WIDTH-1:0]   idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              xor_acc;
`endif

    logic        fire;
    logic        grp_end;
    logic        last_word;
    logic        restart;
    logic [31:0] hdr_val;
    logic [31:0] word_val;

    // ready depends only on state, so it holds through write cycles
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx.ready = (state == S_HDR) || (state == S_DATA) ||
                      (state == S_CSUM);
`else
    assign rx.ready = (state == S_HDR) || (state == S_DATA);
`endif

    assign fire      = rx.valid && rx.ready;
    assign grp_end   = fire && (byte_cnt == 2'd3);
    assign hdr_val   = {count[23:0], rx.data};
    assign word_val  = {word, rx.data};
    assign last_word = (32'(idx) == count - 32'd1);
    assign restart   = ((state == S_DONE) || (state == S_ERR)) && reload;

    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cpu_reset = (state != S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_HDR: begin
                if (grp_end) begin
                    if (hdr_val > DEPTH_W) begin
                        state_n = S_ERR;
                    end else if (hdr_val == 32'd0) begin
                        state_n = TAIL;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (grp_end && last_word) begin
                    state_n = TAIL;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (fire) begin
                    state_n = (rx.data == xor_acc) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_n = S_HDR;
                end
            end
            default: state_n = S_HDR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            count      <= 32'd0;
            word       <= 24'd0;
            idx        <= '0;
            imem_wren  <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc    <= 8'd0;
`endif
        end else begin
            imem_wren <= 1'b0;
            if (restart) begin
                byte_cnt <= 2'd0;
                count    <= 32'd0;
                word     <= 24'd0;
                idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_acc  <= 8'd0;
`endif
            end else if (fire) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (state != S_CSUM) begin
                    xor_acc <= xor_acc ^ rx.data;
                end
`endif
                if (state == S_HDR) begin
                    count <= hdr_val;
                end
                if (state == S_DATA) begin
                    word <= {word[15:0], rx.data};
                    if (grp_end) begin
                        imem_wren  <= 1'b1;
                        imem_addr  <= idx;
                        imem_wdata <= word_val;
                        idx        <= idx + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
